// File: rtl/pixel_writer.sv
// pixel_writer: pulls rasterizer pixels and writes each to the framebuffer.
// Define PIXEL_WRITER_CLIP_EN to drop pixels outside WIDTH x HEIGHT.
module pixel_writer #(
  parameter int          WIDTH      = 640,
  parameter int          HEIGHT     = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          BPP        = 2,
  parameter int          ADDR_W     = 32,
  parameter int          COLOR_W    = 16,
  parameter int          SETTLE_CYC = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COLOR_W-1:0] color,
  input  logic [15:0]        x_i,
  input  logic [15:0]        y_i,
  input  logic               line_complete,
  output logic               get_pixel,
  output logic               busy,
  output logic               done,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [COLOR_W-1:0] mem_writedata,
  input  logic               mem_waitrequest,
  output logic [15:0]        pixel_count
);

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    WRITE,
    ADVANCE,
    SETTLE,
    DONE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic        last;
  logic [3:0]  settle_cnt;
  logic [31:0] addr_calc;
  logic        clip;
  logic        accept;

  assign addr_calc = BASE_ADDR
    + ((32'(y_i) * 32'(WIDTH)) + 32'(x_i))
    * 32'(BPP);

`ifdef PIXEL_WRITER_CLIP_EN
  assign clip = (32'(x_i) >= 32'(WIDTH))
             || (32'(y_i) >= 32'(HEIGHT));
`else
  assign clip = 1'b0;
`endif

  assign accept = (state == WRITE) && !mem_waitrequest;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (start) state_n = SAMPLE;
      SAMPLE:
        if (clip) state_n = line_complete ? DONE : ADVANCE;
        else      state_n = WRITE;
      WRITE:
        if (!mem_waitrequest) state_n = last ? DONE : ADVANCE;
      ADVANCE:
        state_n = SETTLE;
      SETTLE:
        if (settle_cnt == 4'(SETTLE_CYC - 1)) state_n = SAMPLE;
      DONE:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  // Outputs are flops decoded from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      get_pixel     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      pixel_count   <= '0;
      last          <= 1'b0;
      settle_cnt    <= '0;
    end else begin
      get_pixel  <= (state_n == ADVANCE);
      busy       <= (state_n != IDLE);
      done       <= (state_n == DONE);
      mem_write  <= (state_n == WRITE);
      settle_cnt <= (state == SETTLE) ? settle_cnt + 4'd1 : 4'd0;
      if (state == IDLE && start) begin
        mem_writedata <= color;
        pixel_count   <= '0;
      end
      if (state == SAMPLE) begin
        last <= line_complete;
        if (!clip) mem_address <= ADDR_W'(addr_calc);
      end
      if (accept && pixel_count != 16'hFFFF)
        pixel_count <= pixel_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer: table-driven line stimulus with a stepping line-drawer
// model and a wait-state memory slave that records accepted writes.
module tb_pixel_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] color = 16'h0;
  logic [15:0] x_i = 16'h0;
  logic [15:0] y_i = 16'h0;
  logic        line_complete = 1'b0;
  logic        get_pixel;
  logic        busy;
  logic        done;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [15:0] mem_writedata;
  logic        mem_waitrequest = 1'b0;
  logic [15:0] pixel_count;

  always #5 clk = ~clk;

  pixel_writer dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .color           (color),
    .x_i             (x_i),
    .y_i             (y_i),
    .line_complete   (line_complete),
    .get_pixel       (get_pixel),
    .busy            (busy),
    .done            (done),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_writedata   (mem_writedata),
    .mem_waitrequest (mem_waitrequest),
    .pixel_count     (pixel_count)
  );

  typedef struct {
    int          id;
    logic [15:0] x;
    logic [15:0] y;
    logic        last;
    logic        wr;
    logic [31:0] addr;
  } vec_t;

  vec_t        tbl[$];
  vec_t        line[$];
  int          idx;
  logic [31:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int          wr_cyc[$];
  int          gp_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          cyc = 0;
  int          stall_left = 0;
  int          stall_cycles = 0;
  logic [31:0] hold_addr;
  logic [15:0] hold_data;
  int          stable_err = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        clip_wr;

  function automatic vec_t mk(int id, logic [15:0] x, logic [15:0] y,
                              logic last, logic wr, logic [31:0] addr);
    vec_t v;
    v.id = id; v.x = x; v.y = y;
    v.last = last; v.wr = wr; v.addr = addr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic present();
    if (idx < line.size()) begin
      x_i = line[idx].x;
      y_i = line[idx].y;
      line_complete = line[idx].last;
    end
  endtask

  task automatic load_line(input int id);
    line.delete();
    foreach (tbl[i]) if (tbl[i].id == id) line.push_back(tbl[i]);
    idx = 0;
    present();
  endtask

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    gp_cyc.delete();
    done_cnt = 0; done_cyc = -1; stable_err = 0;
  endtask

  task automatic run_line(input int id, input logic [15:0] col,
                          input bit poke, output int sc);
    int t;
    bit poked;
    load_line(id);
    clear_log();
    @(posedge clk); #1;
    start = 1'b1; color = col; sc = cyc;
    @(posedge clk); #1;
    start = 1'b0; color = 16'h0BAD;
    t = 0; poked = 0;
    while (done_cnt == 0 && t < 400) begin
      @(posedge clk); #1;
      t++;
      start = 1'b0;
      // gp seen on the previous negedge: this cycle is SETTLE
      if (poke && !poked && gp_cyc.size() > 0) begin
        start = 1'b1; poked = 1;
      end
    end
    start = 1'b0;
    check($sformatf("done_seen_l%0d", id), 32'(done_cnt != 0), 32'd1);
    check($sformatf("busy_after_done_l%0d", id), 32'(busy), 32'd0);
  endtask

  task automatic compare_writes(input int id, input logic [15:0] col);
    logic [31:0] exp_a[$];
    foreach (line[i]) if (line[i].wr) exp_a.push_back(line[i].addr);
    check($sformatf("write_count_l%0d", id), wr_addr.size(), exp_a.size());
    foreach (exp_a[i]) begin
      if (i < wr_addr.size()) begin
        check($sformatf("addr_l%0d_%0d", id, i), wr_addr[i], exp_a[i]);
        check($sformatf("data_l%0d_%0d", id, i), 32'(wr_data[i]), 32'(col));
      end
    end
    check($sformatf("pixel_count_l%0d", id), 32'(pixel_count), exp_a.size());
  endtask

  initial begin
    int sc;
    int t;

`ifdef PIXEL_WRITER_CLIP_EN
    clip_wr = 1'b0;
`else
    clip_wr = 1'b1;
`endif
    for (int i = 0; i < 11; i++)
      tbl.push_back(mk(0, 16'(10 + i), 16'd50, i == 10, 1'b1,
                       32'h0000_FA14 + 32'(2 * i)));
    tbl.push_back(mk(1, 16'd10, 16'd5, 1'b0, 1'b1, 32'h0000_1914));
    tbl.push_back(mk(1, 16'd11, 16'd5, 1'b1, 1'b1, 32'h0000_1916));
    tbl.push_back(mk(2, 16'd10, 16'd5, 1'b1, 1'b1, 32'h0000_1914));
    tbl.push_back(mk(3, 16'd639, 16'd10, 1'b0, 1'b1, 32'h0000_36FE));
    tbl.push_back(mk(3, 16'd700, 16'd10, 1'b0, clip_wr, 32'h0000_3778));
    tbl.push_back(mk(3, 16'd0, 16'd11, 1'b1, 1'b1, 32'h0000_3700));

    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (get_pixel) begin
          gp_cyc.push_back(cyc);
          idx++;
          present();
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (mem_write && stall_left > 0) begin
          if (stall_cycles == 0) begin
            hold_addr = mem_address;
            hold_data = mem_writedata;
          end else if (mem_address !== hold_addr
                       || mem_writedata !== hold_data) begin
            stable_err++;
          end
          mem_waitrequest = 1'b1;
          stall_left--;
          stall_cycles++;
        end else begin
          mem_waitrequest = 1'b0;
          if (mem_write) begin
            if (stall_cycles > 0 && (mem_address !== hold_addr
                || mem_writedata !== hold_data))
              stable_err++;
            wr_addr.push_back(mem_address);
            wr_data.push_back(mem_writedata);
            wr_cyc.push_back(cyc);
            stall_cycles = 0;
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_get_pixel", 32'(get_pixel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_writedata", 32'(mem_writedata), 32'd0);
    check("rst_pixel_count", 32'(pixel_count), 32'd0);
    reset = 1'b0;

    // horizontal line, no stalls
    run_line(0, 16'hF800, 1'b0, sc);
    compare_writes(0, 16'hF800);
    check("hline_first_write_cyc", 32'(wr_cyc.size() > 0 ? wr_cyc[0] - sc : -1), 32'd3);
    check("hline_gp_count", gp_cyc.size(), 32'd10);
    for (int i = 1; i < gp_cyc.size(); i++)
      check($sformatf("hline_gp_gap_%0d", i), 32'(gp_cyc[i] - gp_cyc[i-1]), 32'd4);
    repeat (3) @(posedge clk);
    #1;
    check("hline_done_once", 32'(done_cnt), 32'd1);

    // 3 wait-states on the first write
    stall_left = 3;
    run_line(1, 16'h07E0, 1'b0, sc);
    compare_writes(1, 16'h07E0);
    check("stall_stable", 32'(stable_err), 32'd0);
    check("stall_accept_cyc", 32'(wr_cyc.size() > 0 ? wr_cyc[0] - sc : -1), 32'd6);

    // single-pixel line
    run_line(2, 16'h001F, 1'b0, sc);
    compare_writes(2, 16'h001F);
    check("single_gp_count", gp_cyc.size(), 32'd0);
    check("single_done_cyc", 32'(done_cyc - sc), 32'd4);

    // out-of-bounds pixel mid-line
    run_line(3, 16'hAAAA, 1'b0, sc);
    compare_writes(3, 16'hAAAA);
    check("clip_gp_count", gp_cyc.size(), 32'd2);

    // reset during a stalled write
    stall_left = 1000;
    load_line(2);
    clear_log();
    @(posedge clk); #1;
    start = 1'b1; color = 16'h5555;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (!mem_write && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("rstw_write_seen", 32'(mem_write), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstw_mem_write", 32'(mem_write), 32'd0);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_pixel_count", 32'(pixel_count), 32'd0);
    reset = 1'b0;
    stall_left = 0;
    stall_cycles = 0;
    repeat (5) @(posedge clk);
    #1;
    check("rstw_no_done", 32'(done_cnt), 32'd0);
    check("rstw_no_write", wr_addr.size(), 32'd0);
    run_line(2, 16'h1357, 1'b0, sc);
    compare_writes(2, 16'h1357);

    // start pulsed during SETTLE must be ignored
    run_line(0, 16'hF800, 1'b1, sc);
    compare_writes(0, 16'hF800);
    check("busy_start_gp_count", gp_cyc.size(), 32'd10);
    repeat (3) @(posedge clk);
    #1;
    check("busy_start_done_once", 32'(done_cnt), 32'd1);
    check("busy_start_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_writer.md
# pixel_writer

- Downstream consumer of the line rasterizer: pulls pixels one at a time with a `get_pixel` request/step handshake.
- For each pixel it computes the linear framebuffer byte address and issues one write on a memory master port that supports wait-states.
- Sits between the line drawer and the frame-buffer memory interconnect; signals `done` when the final pixel of a line has been committed.

## Interface

Parameters:
- WIDTH, 640, frame width in pixels (row pitch)
- HEIGHT, 480, frame height in pixels
- BASE_ADDR, 32'h0000_0000, framebuffer byte base address
- BPP, 2, bytes per pixel
- ADDR_W, 32, memory address width
- COLOR_W, 16, pixel data width
- SETTLE_CYC, 1, cycles waited after `get_pixel` before sampling the next pixel (1–15)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset
- start  in  1  begin consuming a line; first pixel already valid on x_i/y_i
- color  in  COLOR_W  pixel colour, latched on accepted `start`
- x_i  in  16  current pixel x from line drawer
- y_i  in  16  current pixel y from line drawer
- line_complete  in  1  high when x_i/y_i is the final pixel of the line
- get_pixel  out  1  one-cycle pulse: step line drawer to next pixel
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last write completes
- mem_write  out  1  write request
- mem_address  out  ADDR_W  byte address
- mem_writedata  out  COLOR_W  latched colour
- mem_waitrequest  in  1  slave stall; write accepted in a cycle with mem_write=1 and mem_waitrequest=0
- pixel_count  out  16  pixels written for the current line; saturates at 16'hFFFF

## Operation

- **States:** IDLE, SAMPLE, WRITE, ADVANCE, SETTLE, DONE.
- **IDLE:**
  - `start`=1 → latch `color`, clear `pixel_count`, go to SAMPLE.
  - `start` is ignored in all other states.
- **SAMPLE:**
  - Register x_i, y_i and last=line_complete.
  - Compute addr = BASE_ADDR + (y*WIDTH + x)*BPP.
    - Internal arithmetic is 32-bit unsigned, truncated to ADDR_W.
    - Overflow wraps silently.
  - Go to WRITE, or follow the clip rule (see Configuration).
- **WRITE:**
  - mem_write=1; mem_address and mem_writedata stay stable until accepted.
  - On acceptance: increment `pixel_count`. If last → DONE, else → ADVANCE.
- **ADVANCE:** get_pixel=1 for exactly one cycle → SETTLE.
- **SETTLE:** wait SETTLE_CYC cycles → SAMPLE.
- **DONE:** done=1 for one cycle → IDLE.
- **line_complete at `start`:** exactly one pixel is written and get_pixel never pulses.
- **Reset mid-operation:** next edge forces IDLE; any unaccepted write is abandoned with mem_write=0 on that edge; pixel_count is cleared.

## Timing

- **Reset values:** get_pixel=0, busy=0, done=0, mem_write=0, mem_address=0, mem_writedata=0, pixel_count=0.
- **First write:** mem_write rises 2 cycles after the `start` edge (IDLE→SAMPLE→WRITE).
- **Zero-wait pixel period:** 1 WRITE + 1 ADVANCE + SETTLE_CYC + 1 SAMPLE = 4 cycles at default.
- **Each wait-state cycle** adds one cycle in WRITE.
- **`done`** asserts the cycle after the final write is accepted.
- **`busy`** falls in the cycle after `done`.
- **x_i/y_i/line_complete** are sampled only in SAMPLE. The upstream block must present the stepped pixel within SETTLE_CYC cycles of get_pixel.
- **All outputs are registered.** No combinational path from mem_waitrequest to any output.

## Configuration

- **PIXEL_WRITER_CLIP_EN defined:**
  - Pixels with x ≥ WIDTH or y ≥ HEIGHT go SAMPLE → ADVANCE (or → DONE if last). No write is issued.
  - pixel_count does not increment for clipped pixels.
- **Undefined:**
  - Every pixel is written using the wrapped address.
  - No bounds comparators are synthesized.

## Test plan

- **Horizontal line, defaults:**
  - Stimulus: `start` with x_i 10..20, y=50, colour 16'hF800, line_complete on x=20, no stalls.
  - Required: 11 writes, first mem_address=32'h0000_FA14, last 32'h0000_FA28, pixel_count=11, `done` once, get_pixel pulsed 10 times, 4 cycles apart.
- **Wait-state stall:** mem_waitrequest=1 for 3 cycles on the first write → address/data stable throughout, accepted on cycle 4, single pixel_count increment.
- **Single-pixel line:** line_complete=1 at `start`, (10,5) → one write to 32'h0000_1914, get_pixel never asserts, `done` 3 cycles after `start`.
- **Clip (macro on):** pixel (700,10) mid-line → no write for it, pixel_count excludes it, the following pixel is still written. Macro off: write to wrapped address (10*640+700)*2=32'h0000_3778.
- **Reset mid-WRITE:** reset during a stall → mem_write=0 and busy=0 the next cycle, pixel_count=0, no `done`; a subsequent `start` runs normally.
- **Busy `start`:** `start` pulsed during SETTLE → ignored; line count and addresses unchanged.
